// File: rtl/x_stream_gen_pkg.sv
// Shared types and default sizes for the x_stream_gen serial stimulus source.
package x_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } x_stream_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/x_stream_gen_if.sv
// Control/stream bundle between a pattern controller (master) and x_stream_gen (slave).
interface x_stream_gen_if
    import x_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = $clog2(WIDTH) + 1,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeat_cnt;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, abort, pattern, len, repeat_cnt,
        input  x, valid, busy, done, err
    );

    modport slave (
        input  start, abort, pattern, len, repeat_cnt,
        output x, valid, busy, done, err
    );

endinterface

// File: rtl/x_stream_gen.sv
// Serial pattern source: sends pattern[len-1:0] MSB-first, (repeat_cnt+1) times, registered outputs.
// Optional X_STREAM_GEN_PARITY_EN appends an even-parity bit after every repetition.
module x_stream_gen
    import x_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = $clog2(WIDTH) + 1,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    x_stream_gen_if.slave bus
);

    localparam int               IDX_W   = $clog2(WIDTH);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    x_stream_state_t  state_reg, state_next;
    logic [WIDTH-1:0] pat_reg, pat_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] idx_reg, idx_next;
    logic [CNT_W-1:0] rep_reg, rep_next;
    logic             x_reg, x_next;
    logic             valid_reg, valid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
`ifdef X_STREAM_GEN_PARITY_EN
    logic             par_phase_reg, par_phase_next;
    logic             par_acc_reg, par_acc_next;
`endif

    logic len_ok;
    logic start_bit;
    logic adv_bit;
    logic reload_bit;
    logic last_bit;

    assign len_ok     = (bus.len != '0) && (bus.len <= MAX_LEN);
    assign start_bit  = bus.pattern[IDX_W'(bus.len - ONE)];
    assign adv_bit    = pat_reg[IDX_W'(idx_reg - ONE)];
    assign reload_bit = pat_reg[IDX_W'(len_reg - ONE)];

    // idx_reg is the position of the bit currently on x; the stream ends once
    // bit 0 (and its parity bit, if enabled) of the last repetition has been shown.
`ifdef X_STREAM_GEN_PARITY_EN
    assign last_bit = par_phase_reg && (rep_reg == '0);
`else
    assign last_bit = (idx_reg == '0) && (rep_reg == '0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            pat_reg       <= '0;
            len_reg       <= '0;
            idx_reg       <= '0;
            rep_reg       <= '0;
            x_reg         <= 1'b0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
`ifdef X_STREAM_GEN_PARITY_EN
            par_phase_reg <= 1'b0;
            par_acc_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            pat_reg       <= pat_next;
            len_reg       <= len_next;
            idx_reg       <= idx_next;
            rep_reg       <= rep_next;
            x_reg         <= x_next;
            valid_reg     <= valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
`ifdef X_STREAM_GEN_PARITY_EN
            par_phase_reg <= par_phase_next;
            par_acc_reg   <= par_acc_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SHIFT: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (last_bit) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = (bus.start && len_ok) ? SHIFT : IDLE;
            end
        endcase
    end

    always_comb begin
        pat_next       = pat_reg;
        len_next       = len_reg;
        idx_next       = idx_reg;
        rep_next       = rep_reg;
        x_next         = 1'b0;
        valid_next     = 1'b0;
        busy_next      = 1'b0;
        done_next      = 1'b0;
        err_next       = 1'b0;
`ifdef X_STREAM_GEN_PARITY_EN
        par_phase_next = par_phase_reg;
        par_acc_next   = par_acc_reg;
`endif
        case (state_reg)
            SHIFT: begin
                if (!bus.abort) begin
                    if (idx_reg != '0) begin
                        idx_next   = idx_reg - ONE;
                        x_next     = adv_bit;
                        valid_next = 1'b1;
                        busy_next  = 1'b1;
`ifdef X_STREAM_GEN_PARITY_EN
                        par_acc_next = par_acc_reg ^ adv_bit;
                    end else if (!par_phase_reg) begin
                        par_phase_next = 1'b1;
                        x_next         = par_acc_reg;
                        valid_next     = 1'b1;
                        busy_next      = 1'b1;
`endif
                    end else if (rep_reg != '0) begin
                        // Back-to-back reload: next repetition starts without a gap cycle.
                        rep_next   = rep_reg - 1'b1;
                        idx_next   = len_reg - ONE;
                        x_next     = reload_bit;
                        valid_next = 1'b1;
                        busy_next  = 1'b1;
`ifdef X_STREAM_GEN_PARITY_EN
                        par_phase_next = 1'b0;
                        par_acc_next   = reload_bit;
`endif
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    if (len_ok) begin
                        pat_next   = bus.pattern;
                        len_next   = bus.len;
                        idx_next   = bus.len - ONE;
                        rep_next   = bus.repeat_cnt;
                        x_next     = start_bit;
                        valid_next = 1'b1;
                        busy_next  = 1'b1;
`ifdef X_STREAM_GEN_PARITY_EN
                        par_phase_next = 1'b0;
                        par_acc_next   = start_bit;
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
        endcase
    end

    assign bus.x     = x_reg;
    assign bus.valid = valid_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.err   = err_reg;

endmodule
